// File: rtl/cmsdk_ahb_apb_async_master_ctrl_pkg.sv
// rtl/cmsdk_ahb_apb_async_master_ctrl_pkg.sv - shared encodings for the master-side bridge control
package cmsdk_ahb_apb_async_master_ctrl_pkg;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_AHB_ADDR   = 3'd1;
  localparam logic [2:0] ST_AHB_DATA   = 3'd2;
  localparam logic [2:0] ST_APB_SETUP  = 3'd3;
  localparam logic [2:0] ST_APB_ACCESS = 3'd4;

  // AHB transfer types; only bit 1 is driven out of the control block
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [2:0] {
    IDLE       = ST_IDLE,
    AHB_ADDR   = ST_AHB_ADDR,
    AHB_DATA   = ST_AHB_DATA,
    APB_SETUP  = ST_APB_SETUP,
    APB_ACCESS = ST_APB_ACCESS
  } state_t;

endpackage

// File: rtl/cmsdk_ahb_apb_async_master_ctrl_if.sv
// rtl/cmsdk_ahb_apb_async_master_ctrl_if.sv - signal bundle between master-side control and bridge datapath
interface cmsdk_ahb_apb_async_master_ctrl_if;

  // semaphore handshake with the slave domain
  logic m_rx_sema_q;
  logic m_tx_sema_q;
  logic m_tx_sema_en;
  logic m_tx_sema_nxt;
  logic m_mask;

  // buffered attributes of the pending request
  logic m_ad_sel_ahb;
  logic m_ad_sel_apb;
  logic m_ad_write;

  // AHB-Lite master port
  logic HTRANSM_bit1;
  logic HREADYM;
  logic HRESPM;

  // APB4 port
  logic PSELM;
  logic PENABLEM;
  logic PREADYM;
  logic PSLVERRM;

  // response / read-data buffer enables
  logic m_hresp_en;
  logic m_hresp_nxt;
  logic m_rd_en;

  // control block view
  modport master (
    input  m_rx_sema_q, m_tx_sema_q,
    input  m_ad_sel_ahb, m_ad_sel_apb, m_ad_write,
    input  HREADYM, HRESPM, PREADYM, PSLVERRM,
    output m_tx_sema_en, m_tx_sema_nxt, m_mask,
    output HTRANSM_bit1, PSELM, PENABLEM,
    output m_hresp_en, m_hresp_nxt, m_rd_en
  );

  // bridge / buses view
  modport slave (
    output m_rx_sema_q, m_tx_sema_q,
    output m_ad_sel_ahb, m_ad_sel_apb, m_ad_write,
    output HREADYM, HRESPM, PREADYM, PSLVERRM,
    input  m_tx_sema_en, m_tx_sema_nxt, m_mask,
    input  HTRANSM_bit1, PSELM, PENABLEM,
    input  m_hresp_en, m_hresp_nxt, m_rd_en
  );

endinterface

// File: rtl/cmsdk_ahb_apb_async_master_ctrl.sv
// rtl/cmsdk_ahb_apb_async_master_ctrl.sv - master-side control FSM of the async AHB to AHB/APB bridge
module cmsdk_ahb_apb_async_master_ctrl
  import cmsdk_ahb_apb_async_master_ctrl_pkg::*;
#(
  parameter int APB_EN = 1,
  parameter int ERR_EN = 1
) (
  input  logic                                  HCLKM,
  input  logic                                  HRESETMn,
  cmsdk_ahb_apb_async_master_ctrl_if.master     bus
);

  localparam logic APB_ON = (APB_EN != 0);
  localparam logic ERR_ON = (ERR_EN != 0);

  state_t state;
  logic   htrans_q;
  logic   psel_q;
  logic   penable_q;
  logic   pending;
  logic   done;
  logic   resp;
  logic   complete;

  // a request is outstanding while the two semaphores differ
  assign pending = bus.m_rx_sema_q ^ bus.m_tx_sema_q;

  // completion is decided in the cycle the transfer ends, so it depends on the bus ready inputs
  always_comb begin
    done = 1'b0;
    resp = 1'b0;
    case (state)
      IDLE: begin
        // no usable target: answer at once with ERROR regardless of ERR_EN
        if (pending && !bus.m_ad_sel_ahb && !(bus.m_ad_sel_apb && APB_ON)) begin
          done = 1'b1;
          resp = 1'b1;
        end
      end
      AHB_DATA: begin
        if (bus.HREADYM) begin
          done = 1'b1;
          resp = bus.HRESPM & ERR_ON;
        end
      end
      APB_ACCESS: begin
        if (bus.PREADYM) begin
          done = 1'b1;
          resp = bus.PSLVERRM & ERR_ON;
        end
      end
      default: ;
    endcase
  end

  // reset also masks completion so no semaphore toggle can leak out while reset is held
  assign complete          = done & HRESETMn;
  assign bus.m_tx_sema_en  = complete;
  assign bus.m_tx_sema_nxt = ~bus.m_tx_sema_q;
  assign bus.m_mask        = ~pending;
  assign bus.m_hresp_en    = complete;
  assign bus.m_hresp_nxt   = complete & resp;
  assign bus.m_rd_en       = complete & ~bus.m_ad_write;
  assign bus.HTRANSM_bit1  = htrans_q;
  assign bus.PSELM         = psel_q & APB_ON;
  assign bus.PENABLEM      = penable_q & APB_ON;

  // transfer sequencing; bus control outputs are registered alongside the state
  always_ff @(posedge HCLKM or negedge HRESETMn) begin
    if (!HRESETMn) begin
      state     <= IDLE;
      htrans_q  <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pending && bus.m_ad_sel_ahb) begin
            state    <= AHB_ADDR;
            htrans_q <= HTRANS_NONSEQ[1];
          end else if (pending && bus.m_ad_sel_apb && APB_ON) begin
            state  <= APB_SETUP;
            psel_q <= 1'b1;
          end
        end
        AHB_ADDR: begin
          if (bus.HREADYM) begin
            state    <= AHB_DATA;
            htrans_q <= HTRANS_IDLE[1];
          end
        end
        AHB_DATA: begin
          if (bus.HREADYM) begin
            state <= IDLE;
          end
        end
        APB_SETUP: begin
          state     <= APB_ACCESS;
          penable_q <= 1'b1;
        end
        APB_ACCESS: begin
          if (bus.PREADYM) begin
            state     <= IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          htrans_q  <= 1'b0;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmsdk_ahb_apb_async_master_ctrl.sv
// tb/tb_cmsdk_ahb_apb_async_master_ctrl.sv - directed vector bench for the master-side bridge control
module tb_cmsdk_ahb_apb_async_master_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic rx = 1'b0;
  logic sel_ahb = 1'b0;
  logic sel_apb = 1'b0;
  logic wr = 1'b0;
  logic hready = 1'b0;
  logic hresp = 1'b0;
  logic pready = 1'b0;
  logic pslverr = 1'b0;

  logic tx_a, tx_b, tx_c;
  int   cnt_a = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   base = 0;

  always #5 clk = ~clk;

  cmsdk_ahb_apb_async_master_ctrl_if u_if_a ();
  cmsdk_ahb_apb_async_master_ctrl_if u_if_b ();
  cmsdk_ahb_apb_async_master_ctrl_if u_if_c ();

  // a: full featured, b: errors suppressed, c: no APB path
  cmsdk_ahb_apb_async_master_ctrl #(.APB_EN(1), .ERR_EN(1)) u_dut_a (.HCLKM(clk), .HRESETMn(rst_n), .bus(u_if_a.master));
  cmsdk_ahb_apb_async_master_ctrl #(.APB_EN(1), .ERR_EN(0)) u_dut_b (.HCLKM(clk), .HRESETMn(rst_n), .bus(u_if_b.master));
  cmsdk_ahb_apb_async_master_ctrl #(.APB_EN(0), .ERR_EN(1)) u_dut_c (.HCLKM(clk), .HRESETMn(rst_n), .bus(u_if_c.master));

  assign u_if_a.m_rx_sema_q = rx;      assign u_if_b.m_rx_sema_q = rx;      assign u_if_c.m_rx_sema_q = rx;
  assign u_if_a.m_tx_sema_q = tx_a;    assign u_if_b.m_tx_sema_q = tx_b;    assign u_if_c.m_tx_sema_q = tx_c;
  assign u_if_a.m_ad_sel_ahb = sel_ahb; assign u_if_b.m_ad_sel_ahb = sel_ahb; assign u_if_c.m_ad_sel_ahb = sel_ahb;
  assign u_if_a.m_ad_sel_apb = sel_apb; assign u_if_b.m_ad_sel_apb = sel_apb; assign u_if_c.m_ad_sel_apb = sel_apb;
  assign u_if_a.m_ad_write = wr;       assign u_if_b.m_ad_write = wr;       assign u_if_c.m_ad_write = wr;
  assign u_if_a.HREADYM = hready;      assign u_if_b.HREADYM = hready;      assign u_if_c.HREADYM = hready;
  assign u_if_a.HRESPM = hresp;        assign u_if_b.HRESPM = hresp;        assign u_if_c.HRESPM = hresp;
  assign u_if_a.PREADYM = pready;      assign u_if_b.PREADYM = pready;      assign u_if_c.PREADYM = pready;
  assign u_if_a.PSLVERRM = pslverr;    assign u_if_b.PSLVERRM = pslverr;    assign u_if_c.PSLVERRM = pslverr;

  // observed outputs: {htrans1, psel, penable, sema_en, hresp_en, hresp_nxt, rd_en, mask}
  logic [7:0] obs_a, obs_b, obs_c;
  assign obs_a = {u_if_a.HTRANSM_bit1, u_if_a.PSELM, u_if_a.PENABLEM, u_if_a.m_tx_sema_en,
                  u_if_a.m_hresp_en, u_if_a.m_hresp_nxt, u_if_a.m_rd_en, u_if_a.m_mask};
  assign obs_b = {u_if_b.HTRANSM_bit1, u_if_b.PSELM, u_if_b.PENABLEM, u_if_b.m_tx_sema_en,
                  u_if_b.m_hresp_en, u_if_b.m_hresp_nxt, u_if_b.m_rd_en, u_if_b.m_mask};
  assign obs_c = {u_if_c.HTRANSM_bit1, u_if_c.PSELM, u_if_c.PENABLEM, u_if_c.m_tx_sema_en,
                  u_if_c.m_hresp_en, u_if_c.m_hresp_nxt, u_if_c.m_rd_en, u_if_c.m_mask};

  // semaphore registers of the bridge top level, one per instance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_a <= 1'b0;
      tx_b <= 1'b0;
      tx_c <= 1'b0;
    end else begin
      if (u_if_a.m_tx_sema_en) tx_a <= u_if_a.m_tx_sema_nxt;
      if (u_if_b.m_tx_sema_en) tx_b <= u_if_b.m_tx_sema_nxt;
      if (u_if_c.m_tx_sema_en) tx_c <= u_if_c.m_tx_sema_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (u_if_a.m_tx_sema_en) cnt_a <= cnt_a + 1;
  end

  typedef struct {
    string      nm;
    logic [7:0] ins;   // {rx, sel_ahb, sel_apb, write, hready, hresp, pready, pslverr}
    logic [7:0] ea;
    logic [7:0] eb;
    logic [7:0] ec;
  } vec_t;

  vec_t vt[$];

  task automatic add(input string nm, input logic [7:0] ins, input logic [7:0] ea,
                     input logic [7:0] eb, input logic [7:0] ec);
    vec_t v;
    v.nm = nm; v.ins = ins; v.ea = ea; v.eb = eb; v.ec = ec;
    vt.push_back(v);
  endtask

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic reset_mid(input logic use_apb);
    @(negedge clk);
    sel_ahb = !use_apb; sel_apb = use_apb; wr = 1'b0;
    hready = 1'b1; hresp = 1'b0; pready = 1'b0; pslverr = 1'b0;
    rx = ~rx;
    @(negedge clk);
    @(negedge clk);
    hready = 1'b0;
    #1;
    check(use_apb ? "rst_pre_apb_access" : "rst_pre_ahb_data", obs_a,
          use_apb ? 8'b0110_0000 : 8'b0000_0000);
    base = cnt_a;
    #2 rst_n = 1'b0;
    #1;
    check(use_apb ? "rst_async_apb" : "rst_async_ahb", obs_a & 8'hFE, 8'h00);
    rx = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    hready = 1'b1;
    pready = 1'b1;
    #1;
    check("rst_release_idle", obs_a, 8'b0000_0001);
    @(negedge clk);
    #1;
    check("rst_stays_idle", obs_a, 8'b0000_0001);
    check("rst_no_completion", 8'(cnt_a - base), 8'd0);
  endtask

  initial begin
    logic got;
    logic exp_nxt;
    int   kind;

    //          name          rx ahb apb wr hrdy hrsp prdy perr   a            b            c
    add("reset",          8'b0_1_0_0_1_0_1_0, 8'b0000_0001, 8'b0000_0001, 8'b0000_0001);
    add("ahb_rd_req",     8'b1_1_0_0_1_0_1_0, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000);
    add("ahb_rd_addr",    8'b1_1_0_0_1_0_1_0, 8'b1000_0000, 8'b1000_0000, 8'b1000_0000);
    add("ahb_rd_data",    8'b1_1_0_0_1_0_1_0, 8'b0001_1010, 8'b0001_1010, 8'b0001_1010);
    add("ahb_rd_after",   8'b1_1_0_0_1_0_1_0, 8'b0000_0001, 8'b0000_0001, 8'b0000_0001);
    add("ahb_wr_req",     8'b0_1_0_1_1_0_1_0, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000);
    add("ahb_wr_addr_w",  8'b0_1_0_1_0_0_1_0, 8'b1000_0000, 8'b1000_0000, 8'b1000_0000);
    add("ahb_wr_addr",    8'b0_1_0_1_1_0_1_0, 8'b1000_0000, 8'b1000_0000, 8'b1000_0000);
    add("ahb_wr_wait1",   8'b0_1_0_1_0_0_1_0, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000);
    add("ahb_wr_wait2",   8'b0_1_0_1_0_0_1_0, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000);
    add("ahb_wr_wait3",   8'b0_1_0_1_0_0_1_0, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000);
    add("ahb_wr_err1",    8'b0_1_0_1_0_1_1_0, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000);
    add("ahb_wr_err2",    8'b0_1_0_1_1_1_1_0, 8'b0001_1100, 8'b0001_1000, 8'b0001_1100);
    add("ahb_wr_after",   8'b0_1_0_1_1_0_1_0, 8'b0000_0001, 8'b0000_0001, 8'b0000_0001);
    add("apb_wr_req",     8'b1_0_1_1_1_0_0_0, 8'b0000_0000, 8'b0000_0000, 8'b0001_1100);
    add("apb_wr_setup",   8'b1_0_1_1_1_0_0_0, 8'b0100_0000, 8'b0100_0000, 8'b0000_0001);
    add("apb_wr_wait1",   8'b1_0_1_1_1_0_0_0, 8'b0110_0000, 8'b0110_0000, 8'b0000_0001);
    add("apb_wr_wait2",   8'b1_0_1_1_1_0_0_0, 8'b0110_0000, 8'b0110_0000, 8'b0000_0001);
    add("apb_wr_err",     8'b1_0_1_1_1_0_1_1, 8'b0111_1100, 8'b0111_1000, 8'b0000_0001);
    add("apb_wr_after",   8'b1_0_1_1_1_0_1_0, 8'b0000_0001, 8'b0000_0001, 8'b0000_0001);
    add("apb_rd_req",     8'b0_0_1_0_1_0_1_0, 8'b0000_0000, 8'b0000_0000, 8'b0001_1110);
    add("apb_rd_setup",   8'b0_0_1_0_1_0_1_0, 8'b0100_0000, 8'b0100_0000, 8'b0000_0001);
    add("apb_rd_access",  8'b0_0_1_0_1_0_1_0, 8'b0111_1010, 8'b0111_1010, 8'b0000_0001);
    add("apb_rd_after",   8'b0_0_1_0_1_0_1_0, 8'b0000_0001, 8'b0000_0001, 8'b0000_0001);
    add("nosel_rd",       8'b1_0_0_0_1_0_1_0, 8'b0001_1110, 8'b0001_1110, 8'b0001_1110);
    add("nosel_rd_after", 8'b1_0_0_0_1_0_1_0, 8'b0000_0001, 8'b0000_0001, 8'b0000_0001);
    add("nosel_wr",       8'b0_0_0_1_1_0_1_0, 8'b0001_1100, 8'b0001_1100, 8'b0001_1100);
    add("nosel_wr_after", 8'b0_0_0_1_1_0_1_0, 8'b0000_0001, 8'b0000_0001, 8'b0000_0001);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("sema_nxt_after_reset", {7'b0, u_if_a.m_tx_sema_nxt}, 8'h01);

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      {rx, sel_ahb, sel_apb, wr, hready, hresp, pready, pslverr} = vt[i].ins;
      #1;
      check({vt[i].nm, "/a"}, obs_a, vt[i].ea);
      check({vt[i].nm, "/b"}, obs_b, vt[i].eb);
      check({vt[i].nm, "/c"}, obs_c, vt[i].ec);
    end

    // back-to-back requests with random select, direction and bus stalls
    base = cnt_a;
    for (int k = 0; k < 100; k++) begin
      got = 1'b0;
      @(negedge clk);
      kind = $urandom_range(0, 2);
      sel_ahb = (kind == 0);
      sel_apb = (kind == 1);
      wr = 1'($urandom_range(0, 1));
      rx = ~rx;
      for (int c = 0; c < 40 && !got; c++) begin
        if (c > 0) @(negedge clk);
        hready  = 1'($urandom_range(0, 1));
        hresp   = 1'($urandom_range(0, 1));
        pready  = 1'($urandom_range(0, 1));
        pslverr = 1'($urandom_range(0, 1));
        #1;
        if (u_if_a.m_tx_sema_en) begin
          got = 1'b1;
          exp_nxt = (kind == 2) ? 1'b1 : ((kind == 0) ? hresp : pslverr);
          check("b2b_resp", {6'b0, u_if_a.m_hresp_nxt, u_if_a.m_rd_en}, {6'b0, exp_nxt, ~wr});
        end
      end
      if (!got) check("b2b_timeout", {7'b0, got}, 8'h01);
      @(negedge clk);
      #1;
      check("b2b_pending_drop", {7'b0, u_if_a.m_mask}, 8'h01);
    end
    @(negedge clk);
    check("b2b_count", 8'(cnt_a - base), 8'd100);
    check("b2b_sema_match", {7'b0, tx_a}, {7'b0, rx});

    reset_mid(1'b0);
    reset_mid(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
